prach_hb1_sched: RTL and testbench
==================================

PRACH_HB1_SCHED -- requirements
Module: prach_hb1_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of time-multiplexed carriers fed to the HB1 filter; legal range 1..256.
REQ-002 SHALL have parameter SLOT_LEN, default 16: cycles per TDM frame; SLOT_LEN >= NUM_CH required, elaboration error otherwise.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port run_en, input, 1: level; 1 = run the frame schedule.
REQ-006 SHALL have port ch_en, input, NUM_CH: per-carrier enable mask, quasi-static.
REQ-007 SHALL have port ch_req, input, NUM_CH: per-carrier one-cycle pulse, new sample available.
REQ-008 SHALL have port ovf_clr, input, 1: pulse; clears all overflow flags.
REQ-009 SHALL have port ch_ack, output, NUM_CH: one-hot grant; sample of that carrier consumed this cycle.
REQ-010 SHALL have port mux_sel, output, 8: carrier index for the external sample mux.
REQ-011 SHALL have port hb_dv, output, 1: drives HB1 din_dv.
REQ-012 SHALL have port hb_chn, output, 8: drives HB1 din_chn.
REQ-013 SHALL have port hb_sync, output, 1: drives HB1 sync_in; frame-start pulse.
REQ-014 SHALL have port ovf, output, NUM_CH: sticky per-carrier overflow flags.
REQ-015 SHALL have port busy, output, 1: 1 whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN plus slot counter s in 0..SLOT_LEN-1.
REQ-017 IDLE: s = 0; run_en=1 -> RUN next cycle, s = 0 on entry.
REQ-018 RUN: s increments each cycle; run_en=0 while s<SLOT_LEN-1 -> DRAIN.
REQ-019 DRAIN: s keeps incrementing; run_en=1 -> RUN with no break in the count.
REQ-020 RUN or DRAIN at s = SLOT_LEN-1: run_en=1 -> RUN with s = 0 next cycle; else -> IDLE; frames are never truncated.
REQ-021 SHALL keep pending bit per carrier: set by ch_req[k] & ch_en[k] in RUN/DRAIN; cleared at its grant; all pending cleared in IDLE; ch_req ignored in IDLE.
REQ-022 In RUN/DRAIN at slot s=k, k<NUM_CH: next cycle hb_chn = mux_sel = k, hb_dv = ch_ack[k] = pending[k] & ch_en[k]; pending[k] cleared on that edge. Latency 1 cycle, all outputs registered.
REQ-023 Slots s >= NUM_CH SHALL be idle: hb_dv=0, ch_ack=0, hb_chn/mux_sel hold last value.
REQ-024 hb_sync SHALL be 1 for exactly the output cycle of slot s=0 of every frame, independent of hb_dv.
REQ-025 At most one ch_ack bit SHALL be 1 per cycle; hb_dv SHALL equal OR of ch_ack.
REQ-026 ch_req[k] while pending[k]=1 and no grant to k on that edge SHALL set ovf[k]; sample is dropped (pending stays 1).
REQ-027 ch_req[k] on the same edge as grant to k SHALL re-set pending[k], ovf[k] unchanged.
REQ-028 ch_en[k]=0 SHALL suppress pending, ack and ovf setting for k; an existing pending[k] is cleared without grant.
REQ-029 ovf_clr SHALL clear all ovf; ovf_clr coincident with a new overflow event leaves that bit set.
REQ-030 hb_chn and mux_sel are zero-extended to 8 bits.

Reset
REQ-031 rst=1 on a clock edge SHALL force IDLE, s=0, pending=0, ovf=0, and all outputs 0, overriding every other input, including mid-frame.
REQ-032 First RUN cycle after rst release requires run_en=1 sampled after reset.

Verification (NUM_CH=4, SLOT_LEN=8)
REQ-033 Reset mid-frame: rst at s=5 -> next cycle busy=0, hb_sync=0, hb_dv=0, ovf=0; run_en held 1 -> hb_sync exactly 2 cycles after rst release.
REQ-034 Steady state: all ch_en=1, ch_req[k] pulsed once per frame before slot k -> hb_chn 0,1,2,3 with hb_dv=1, 4 idle cycles, hb_sync every 8 cycles with chn 0.
REQ-035 Overflow: two ch_req[2] pulses within one frame before slot 2 -> ovf[2]=1, single ack for 2; ovf_clr -> ovf=0.
REQ-036 Same-edge: ch_req[1] on grant edge of carrier 1 -> ack[1]=1, next frame ack[1]=1 again, ovf[1]=0.
REQ-037 Drain: run_en dropped at s=2 -> slots 3..7 complete, busy falls after s=7, no hb_sync; run_en re-raised at s=5 -> hb_sync continues uninterrupted.
REQ-038 Masking: ch_en=4'b1010 with all ch_req pulsing -> acks only on carriers 1,3; ovf[0], ovf[2] stay 0.

Source files
------------

// File: rtl/prach_hb1_sched.sv
// rtl/prach_hb1_sched.sv - TDM frame scheduler feeding HB1 filter inputs.
// Grants one carrier per slot from a per-carrier pending bit; all outputs are registered.
module prach_hb1_sched #(
    parameter int NUM_CH   = 8,
    parameter int SLOT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic              ovf_clr,
    output logic [NUM_CH-1:0] ch_ack,
    output logic [7:0]        mux_sel,
    output logic              hb_dv,
    output logic [7:0]        hb_chn,
    output logic              hb_sync,
    output logic [NUM_CH-1:0] ovf,
    output logic              busy
);

    localparam int            SW     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(SLOT_LEN - 1);

    if (NUM_CH < 1 || NUM_CH > 256) begin : g_bad_num_ch
        $error("prach_hb1_sched: NUM_CH must be in 1..256");
    end
    if (SLOT_LEN < NUM_CH) begin : g_bad_slot_len
        $error("prach_hb1_sched: SLOT_LEN must be >= NUM_CH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [7:0]        sel_q, sel_d;
    logic              dv_q, dv_d;
    logic              sync_q, sync_d;
    logic [31:0]       s_ext;
    logic              in_chan;

    assign s_ext   = 32'(s_q);
    assign in_chan = (state_q != IDLE) && (s_ext < 32'(NUM_CH));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        pend_d  = pend_q;
        ovf_d   = ovf_clr ? '0 : ovf_q;
        ack_d   = '0;
        sel_d   = sel_q;
        dv_d    = 1'b0;
        sync_d  = 1'b0;
        case (state_q)
            IDLE: begin
                s_d    = '0;
                pend_d = '0;
                if (run_en) begin
                    state_d = RUN;
                end
            end
            default: begin
                // A started frame always runs to its last slot; run_en only picks what follows.
                if (s_q == S_LAST) begin
                    s_d     = '0;
                    state_d = run_en ? RUN : IDLE;
                end else begin
                    s_d     = s_q + 1'b1;
                    state_d = run_en ? RUN : DRAIN;
                end
                sync_d = (s_q == '0);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!ch_en[k]) begin
                        pend_d[k] = 1'b0;
                    end else if (in_chan && s_ext == 32'(k)) begin
                        ack_d[k]  = pend_q[k];
                        pend_d[k] = ch_req[k];
                    end else begin
                        // A request onto an occupied pending bit is dropped and flagged.
                        if (ch_req[k] && pend_q[k]) begin
                            ovf_d[k] = 1'b1;
                        end
                        pend_d[k] = pend_q[k] | ch_req[k];
                    end
                end
                if (in_chan) begin
                    sel_d = s_ext[7:0];
                end
                dv_d = |ack_d;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            ack_q   <= '0;
            sel_q   <= '0;
            dv_q    <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            dv_q    <= dv_d;
            sync_q  <= sync_d;
        end
    end

    assign ch_ack  = ack_q;
    assign mux_sel = sel_q;
    assign hb_chn  = sel_q;
    assign hb_dv   = dv_q;
    assign hb_sync = sync_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_prach_hb1_sched.sv
// tb/tb_prach_hb1_sched.sv - directed bench for prach_hb1_sched with NUM_CH=4, SLOT_LEN=8.
module tb_prach_hb1_sched;

    logic       clk;
    logic       rst;
    logic       run_en;
    logic [3:0] ch_en;
    logic [3:0] ch_req;
    logic       ovf_clr;
    logic [3:0] ch_ack;
    logic [7:0] mux_sel;
    logic       hb_dv;
    logic [7:0] hb_chn;
    logic       hb_sync;
    logic [3:0] ovf;
    logic       busy;

    int tests = 0;
    int fails = 0;

    prach_hb1_sched #(.NUM_CH(4), .SLOT_LEN(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .run_en  (run_en),
        .ch_en   (ch_en),
        .ch_req  (ch_req),
        .ovf_clr (ovf_clr),
        .ch_ack  (ch_ack),
        .mux_sel (mux_sel),
        .hb_dv   (hb_dv),
        .hb_chn  (hb_chn),
        .hb_sync (hb_sync),
        .ovf     (ovf),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-slot frame starting at s=0; reqv nibble s is ch_req at slot s, runv bit s is run_en.
    task automatic run_frame(input string name, input logic [31:0] reqv, input logic [7:0] runv,
                             input logic clr7, input logic [3:0] exp_ack, input logic [3:0] exp_ovf);
        logic ga;
        for (int s = 0; s < 8; s++) begin
            ch_req  = reqv[4*s +: 4];
            run_en  = runv[s];
            ovf_clr = clr7 && (s == 7);
            tick();
            chk($sformatf("%s sync s%0d", name, s), 32'(hb_sync), 32'(s == 0));
            chk($sformatf("%s busy s%0d", name, s), 32'(busy), 32'((s < 7) || runv[7]));
            if (s < 4) begin
                ga = exp_ack[s];
                chk($sformatf("%s ack s%0d", name, s), 32'(ch_ack), ga ? (32'd1 << s) : 32'd0);
                chk($sformatf("%s dv s%0d", name, s), 32'(hb_dv), 32'(ga));
                chk($sformatf("%s chn s%0d", name, s), 32'(hb_chn), 32'(s));
                chk($sformatf("%s mux s%0d", name, s), 32'(mux_sel), 32'(s));
            end else begin
                chk($sformatf("%s ack s%0d", name, s), 32'(ch_ack), 32'd0);
                chk($sformatf("%s dv s%0d", name, s), 32'(hb_dv), 32'd0);
                chk($sformatf("%s chn s%0d", name, s), 32'(hb_chn), 32'd3);
                chk($sformatf("%s mux s%0d", name, s), 32'(mux_sel), 32'd3);
            end
        end
        ch_req  = '0;
        ovf_clr = 1'b0;
        chk($sformatf("%s ovf", name), 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        rst     = 1'b1;
        run_en  = 1'b1;
        ch_en   = 4'hF;
        ch_req  = 4'hF;
        ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sync", 32'(hb_sync), 32'd0);
        chk("rst dv", 32'(hb_dv), 32'd0);
        chk("rst ack", 32'(ch_ack), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst mux", 32'(mux_sel), 32'd0);

        ch_req = '0;
        rst    = 1'b0;
        tick();
        chk("enter busy", 32'(busy), 32'd1);
        chk("enter sync", 32'(hb_sync), 32'd0);

        run_frame("f0", 32'h00F0_0000, 8'hFF, 1'b0, 4'h0, 4'h0);
        run_frame("f1", 32'h00F0_0000, 8'hFF, 1'b0, 4'hF, 4'h0);
        run_frame("f2", 32'h00B0_0000, 8'hFF, 1'b0, 4'hF, 4'h0);
        run_frame("ovf", 32'h00F0_0044, 8'hFF, 1'b0, 4'hF, 4'h4);
        run_frame("clr", 32'h00F0_0000, 8'hFF, 1'b1, 4'hF, 4'h0);
        run_frame("clrhit", 32'h40F0_0000, 8'hFF, 1'b1, 4'hF, 4'h4);
        run_frame("same", 32'h0000_0020, 8'hFF, 1'b0, 4'hF, 4'h4);
        run_frame("same2", 32'h0000_0000, 8'hFF, 1'b1, 4'h2, 4'h0);

        ch_en = 4'b1010;
        run_frame("mask", 32'h00FF_0000, 8'hFF, 1'b0, 4'h0, 4'hA);
        run_frame("mask2", 32'h00F0_0000, 8'hFF, 1'b1, 4'hA, 4'h0);
        ch_en = 4'b0000;
        run_frame("off", 32'h0000_0000, 8'hFF, 1'b0, 4'h0, 4'h0);
        ch_en = 4'hF;
        run_frame("on", 32'h0000_0000, 8'hFF, 1'b0, 4'h0, 4'h0);

        run_frame("drain1", 32'h0008_0000, 8'hE3, 1'b0, 4'h0, 4'h0);
        run_frame("drain2", 32'h0000_0000, 8'h03, 1'b0, 4'h8, 4'h0);
        run_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("idle busy %0d", i), 32'(busy), 32'd0);
            chk($sformatf("idle sync %0d", i), 32'(hb_sync), 32'd0);
            chk($sformatf("idle dv %0d", i), 32'(hb_dv), 32'd0);
        end

        run_en = 1'b1;
        tick();
        chk("re busy", 32'(busy), 32'd1);
        chk("re sync", 32'(hb_sync), 32'd0);
        for (int s = 0; s < 5; s++) begin
            ch_req = (s == 2 || s == 3) ? 4'b0001 : 4'b0000;
            tick();
        end
        ch_req = '0;
        chk("pre-rst ovf", 32'(ovf), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst sync", 32'(hb_sync), 32'd0);
        chk("mid rst dv", 32'(hb_dv), 32'd0);
        chk("mid rst ovf", 32'(ovf), 32'd0);
        chk("mid rst mux", 32'(mux_sel), 32'd0);
        rst = 1'b0;
        tick();
        chk("post rst sync1", 32'(hb_sync), 32'd0);
        chk("post rst busy1", 32'(busy), 32'd1);
        tick();
        chk("post rst sync2", 32'(hb_sync), 32'd1);
        chk("post rst dv2", 32'(hb_dv), 32'd0);
        chk("post rst chn2", 32'(hb_chn), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
